scaler_axis_cfggen: RTL and testbench
=====================================

// Module: scaler_axis_cfggen
// PURPOSE
// Parametrised one-axis scaler configuration generator. Instantiated once per axis (V and H) in the PPU.
// From native input count, optional boxed window, target active size and scaled output size, it computes:
// - first input position to read, input elements needed and the interpolation step factor.
// Adds user shift, error flag, restart-on-change and a valid/ack hand-off to the scaler.
// PARAMETERS
// IN_W      10  width of input element counts (lines/pixels), max 1023
// ACT_W     12  width of target active count
// OUT_W     12  width of scaled output count
// FRAC_W    18  divider dividend width; factor = 2^(FRAC_W-1)/out
// WAIT_CYC  4   settle cycles after divide for the multiply pipeline (>=3)
// PORTS
// SYS_CLK          in   1       system clock
// SYS_RST          in   1       asynchronous reset, active-high
// full_in_i        in   IN_W    native input count (240/288 lines, 320/640 pixels)
// boxed_in_i       in   IN_W    window count centred inside full_in_i (e.g. 240 in 288)
// boxed_en_i       in   1       1: scale boxed_in_i window, 0: scale full_in_i
// active_i         in   ACT_W   target active output size incl. overscan
// out_i            in   OUT_W   scaled output count (divisor)
// shift_i          in   IN_W    signed two's-complement offset added to first read position
// cfg_ack_i        in   1       scaler accepted presented config
// pos_1st_o        out  IN_W    first input element to read
// in_needed_o      out  IN_W    input elements needed
// in_full_o        out  IN_W    native input count (copy of latched full_in_i)
// out_o            out  OUT_W   latched out_i
// interp_factor_o  out  FRAC_W  step factor F
// cfg_valid_o      out  1       config presented, held until ack
// cfg_err_o        out  1       latched out_i was 0
// busy_o           out  1       FSM not in IDLE
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; latched input copies 0; divider command idle.
// - Inputs registered once (_L). IDLE compares the _L set against the latched _LL set.
//   On any mismatch, and when the divider is not busy: copy _L to _LL, pulse div cmd, go to DIV.
// - FSM IDLE->DIV->CALC->PRESENT->IDLE.
//   - DIV: wait for divider done.
//   - CALC: count WAIT_CYC cycles.
//   - PRESENT: drive outputs and cfg_valid_o=1. Outputs stay stable until cfg_ack_i, then go to IDLE.
//   - cfg_valid_o falls in the cycle after ack.
// - Restart: in DIV or CALC, an _L/_LL mismatch aborts and returns to IDLE. Divider result is discarded.
//   The new set is relatched once the divider is not busy. No partial config is ever presented.
// - Changes during PRESENT are taken only after ack; IDLE then restarts the next cycle.
// - Arithmetic, using the _LL set:
//   - base = boxed_en ? boxed_in : full_in.
//   - F = floor(2^(FRAC_W-1)/out), full FRAC_W bits.
//   - P = F*base*active, width FRAC_W+IN_W+ACT_W, no truncation.
//   - raw = (P >> (FRAC_W-1)) + P[FRAC_W-2] (round half up).
//   - needed = (raw < base) ? raw : base.
//   - c = (base-needed)>>1.
//   - pos = clamp(c + shift, 0, base-needed) + (boxed_en ? (full_in-base)>>1 : 0).
//   - boxed_in > full_in is treated as base = full_in.
// - out==0: no divide; F = all ones, needed = base, pos = boxed offset only, cfg_err_o=1. Still presented via handshake.
// - ack while cfg_valid_o=0 is ignored.
// - Reset mid-operation returns to reset state immediately. Pending divide is abandoned.
// - Latency from input change to cfg_valid_o: 2 + divider latency + WAIT_CYC + 1 cycles.
// STRUCTURE
// - Shared package/header: FSM state encodings (ST_IDLE/ST_DIV/ST_CALC/ST_PRESENT) and default NTSC/PAL/pixel counts.
// - One sub-module: serial_divide (existing) with DIVIDEND_WIDTH=FRAC_W, DIVISOR_WIDTH=OUT_W. Dividend is 2^(FRAC_W-1).
// - Multipliers are registered DSP stages: F*base, then *active. Both settle within CALC.
// TESTING
// 1 full=240,boxed_en=0,active=480,out=480,shift=0 -> F=273,needed=240,pos=0,valid until ack
// 2 full=240,active=960,out=1080 -> F=121,needed=213,pos=13
// 3 full=288,boxed=240,boxed_en=1,active=480,out=480 -> needed=240,pos=24,in_full=288
// 4 case 2 with shift=+20 -> pos=27 (clamped); shift=-20 -> pos=0
// 5 out=0 -> cfg_err=1,F=0x3FFFF,needed=240; then out=480 -> err clears after re-present
// 6 change out mid-DIV -> no valid for old value, single present for new; SYS_RST in CALC -> all outputs 0

Source files
------------

// File: rtl/scaler_axis_cfggen_pkg.sv
// Shared definitions for the per-axis scaler configuration generator.
package scaler_axis_cfggen_pkg;

    // Configuration sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV     = 2'd1,
        ST_CALC    = 2'd2,
        ST_PRESENT = 2'd3
    } cfg_state_t;

    // Native input counts seen by the PPU
    localparam int NTSC_LINES = 240;
    localparam int PAL_LINES  = 288;
    localparam int PIX_LO     = 320;
    localparam int PIX_HI     = 640;

endpackage

// File: rtl/scaler_axis_cfggen_serial_divide.sv
// Restoring serial divider: one quotient bit per clock, MSB first.
// A start pulse while idle latches the operands; done pulses for one
// cycle with the quotient valid DIVIDEND_WIDTH cycles later.
module serial_divide #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 12
) (
    input  logic                      SYS_CLK,
    input  logic                      SYS_RST,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0] rem;
    logic [DIVISOR_WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0]         cnt;
    logic [DIVISOR_WIDTH:0]   trial;
    logic [DIVISOR_WIDTH-1:0] diff;
    logic                     ge;

    // Trial subtraction for the next quotient bit; the remainder after a
    // successful subtract is below the divisor, so the low bits suffice.
    always_comb begin
        trial = {rem, quotient[DIVIDEND_WIDTH-1]};
        ge    = (trial >= {1'b0, divisor_q});
        diff  = trial[DIVISOR_WIDTH-1:0] - divisor_q;
    end

    // Iteration register: load on start, shift one bit per cycle while busy
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            rem       <= '0;
            divisor_q <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
        end else if (start && !busy) begin
            rem       <= '0;
            quotient  <= dividend;
            divisor_q <= divisor;
            cnt       <= CNT_W'(DIVIDEND_WIDTH);
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (busy) begin
            rem      <= ge ? diff : trial[DIVISOR_WIDTH-1:0];
            quotient <= {quotient[DIVIDEND_WIDTH-2:0], ge};
            cnt      <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/scaler_axis_cfggen.sv
// One-axis scaler configuration generator: derives first read position,
// input elements needed and interpolation step from the axis geometry and
// hands the result to the scaler with a valid/ack handshake.
module scaler_axis_cfggen
    import scaler_axis_cfggen_pkg::*;
#(
    parameter int IN_W     = 10,
    parameter int ACT_W    = 12,
    parameter int OUT_W    = 12,
    parameter int FRAC_W   = 18,
    parameter int WAIT_CYC = 4
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic [IN_W-1:0]   full_in_i,
    input  logic [IN_W-1:0]   boxed_in_i,
    input  logic              boxed_en_i,
    input  logic [ACT_W-1:0]  active_i,
    input  logic [OUT_W-1:0]  out_i,
    input  logic [IN_W-1:0]   shift_i,
    input  logic              cfg_ack_i,
    output logic [IN_W-1:0]   pos_1st_o,
    output logic [IN_W-1:0]   in_needed_o,
    output logic [IN_W-1:0]   in_full_o,
    output logic [OUT_W-1:0]  out_o,
    output logic [FRAC_W-1:0] interp_factor_o,
    output logic              cfg_valid_o,
    output logic              cfg_err_o,
    output logic              busy_o
);

    localparam int MUL1_W = FRAC_W + IN_W;
    localparam int PROD_W = FRAC_W + IN_W + ACT_W;
    localparam int RAW_W  = PROD_W - FRAC_W + 2;
    localparam int CNT_W  = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [FRAC_W-1:0] DIVIDEND = {1'b1, {(FRAC_W-1){1'b0}}};

    // Input copies: _l is the registered input, _ll the set being worked on
    logic [IN_W-1:0]  full_l,   full_ll;
    logic [IN_W-1:0]  boxed_l,  boxed_ll;
    logic             boxed_en_l, boxed_en_ll;
    logic [ACT_W-1:0] active_l, active_ll;
    logic [OUT_W-1:0] out_l,    out_ll;
    logic [IN_W-1:0]  shift_l,  shift_ll;
    logic             mismatch;

    cfg_state_t       state, state_nxt;
    logic             relatch, div_start, f_load, out_load;
    logic [CNT_W-1:0] wait_cnt;

    logic              div_busy, div_done;
    logic [FRAC_W-1:0] div_quo;

    logic [FRAC_W-1:0] f_q;
    logic [MUL1_W-1:0] mul1;
    logic [PROD_W-1:0] mul2;

    logic                   boxed_use;
    logic [IN_W-1:0]        base, offset, needed, lim, c, clamped, pos;
    logic [RAW_W-1:0]       raw;
    logic signed [IN_W+1:0] sum;

    // Register the raw inputs once
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (SYS_RST) begin
            full_l     <= '0;
            boxed_l    <= '0;
            boxed_en_l <= 1'b0;
            active_l   <= '0;
            out_l      <= '0;
            shift_l    <= '0;
        end else begin
            full_l     <= full_in_i;
            boxed_l    <= boxed_in_i;
            boxed_en_l <= boxed_en_i;
            active_l   <= active_i;
            out_l      <= out_i;
            shift_l    <= shift_i;
        end
    end

    // Capture the working set when a new calculation starts
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            full_ll     <= '0;
            boxed_ll    <= '0;
            boxed_en_ll <= 1'b0;
            active_ll   <= '0;
            out_ll      <= '0;
            shift_ll    <= '0;
        end else if (relatch) begin
            full_ll     <= full_l;
            boxed_ll    <= boxed_l;
            boxed_en_ll <= boxed_en_l;
            active_ll   <= active_l;
            out_ll      <= out_l;
            shift_ll    <= shift_l;
        end
    end

    assign mismatch = (full_l != full_ll) || (boxed_l != boxed_ll) ||
                      (boxed_en_l != boxed_en_ll) || (active_l != active_ll) ||
                      (out_l != out_ll) || (shift_l != shift_ll);

    serial_divide #(
        .DIVIDEND_WIDTH (FRAC_W),
        .DIVISOR_WIDTH  (OUT_W)
    ) u_div (
        .SYS_CLK  (SYS_CLK),
        .SYS_RST  (SYS_RST),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (out_l),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Sequencer state register
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state and control strobes; any input change in DIV/CALC aborts
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_nxt = state;
        relatch   = 1'b0;
        div_start = 1'b0;
        f_load    = 1'b0;
        out_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mismatch && !div_busy) begin
                    relatch   = 1'b1;
                    div_start = (out_l != '0);
                    state_nxt = ST_DIV;
                end
            end
            ST_DIV: begin
                if (mismatch) begin
                    state_nxt = ST_IDLE;
                end else if (out_ll == '0 || div_done) begin
                    f_load    = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (mismatch) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    out_load  = 1'b1;
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (cfg_ack_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Settle counter for the multiply pipeline, running only in CALC
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST)               wait_cnt <= '0;
        else if (state == ST_CALC) wait_cnt <= wait_cnt + 1'b1;
        else                       wait_cnt <= '0;
    end

    // Step factor: quotient of the divide, saturated when out is zero
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST)     f_q <= '0;
        else if (f_load) f_q <= (out_ll == '0) ? '1 : div_quo;
    end

    // Two registered multiply stages: F*base, then *active
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            mul1 <= '0;
            mul2 <= '0;
        end else begin
            mul1 <= MUL1_W'(f_q) * MUL1_W'(base);
            mul2 <= PROD_W'(mul1) * PROD_W'(active_ll);
        end
    end

    // Window geometry and clamped first position from the settled product
    always_comb begin
        boxed_use = boxed_en_ll && (boxed_ll <= full_ll);
        base      = boxed_use ? boxed_ll : full_ll;
        offset    = boxed_use ? ((full_ll - boxed_ll) >> 1) : '0;
        raw       = RAW_W'(mul2 >> (FRAC_W - 1)) + RAW_W'(mul2[FRAC_W-2]);
        if (out_ll == '0 || raw >= RAW_W'(base)) needed = base;
        else                                     needed = raw[IN_W-1:0];
        lim = base - needed;
        c   = lim >> 1;
        sum = $signed({2'b00, c}) + $signed({{2{shift_ll[IN_W-1]}}, shift_ll});
        if (sum < 0)                          clamped = '0;
        else if (sum > $signed({2'b00, lim})) clamped = lim;
        else                                  clamped = sum[IN_W-1:0];
        pos = clamped + offset;
    end

    // Presented configuration, loaded on entry to PRESENT and held
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            pos_1st_o       <= '0;
            in_needed_o     <= '0;
            in_full_o       <= '0;
            out_o           <= '0;
            interp_factor_o <= '0;
            cfg_err_o       <= 1'b0;
        end else if (out_load) begin
            pos_1st_o       <= pos;
            in_needed_o     <= needed;
            in_full_o       <= full_ll;
            out_o           <= out_ll;
            interp_factor_o <= f_q;
            cfg_err_o       <= (out_ll == '0);
        end
    end

    assign cfg_valid_o = (state == ST_PRESENT);
    assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_scaler_axis_cfggen.sv
// Scoreboard bench for scaler_axis_cfggen: expected configurations are
// queued as stimulus is applied and compared as the DUT presents them.
module tb_scaler_axis_cfggen;

    localparam int IN_W   = 10;
    localparam int ACT_W  = 12;
    localparam int OUT_W  = 12;
    localparam int FRAC_W = 18;

    typedef struct {
        logic [IN_W-1:0]   pos;
        logic [IN_W-1:0]   needed;
        logic [IN_W-1:0]   full;
        logic [OUT_W-1:0]  out;
        logic [FRAC_W-1:0] f;
        logic              err;
    } exp_t;

    logic              SYS_CLK = 1'b0;
    logic              SYS_RST = 1'b1;
    logic [IN_W-1:0]   full_in_i  = '0;
    logic [IN_W-1:0]   boxed_in_i = '0;
    logic              boxed_en_i = 1'b0;
    logic [ACT_W-1:0]  active_i   = '0;
    logic [OUT_W-1:0]  out_i      = '0;
    logic [IN_W-1:0]   shift_i    = '0;
    logic              cfg_ack_i  = 1'b0;
    logic [IN_W-1:0]   pos_1st_o, in_needed_o, in_full_o;
    logic [OUT_W-1:0]  out_o;
    logic [FRAC_W-1:0] interp_factor_o;
    logic              cfg_valid_o, cfg_err_o, busy_o;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   fails  = 0;

    scaler_axis_cfggen #(
        .IN_W(IN_W), .ACT_W(ACT_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W), .WAIT_CYC(4)
    ) dut (
        .SYS_CLK         (SYS_CLK),
        .SYS_RST         (SYS_RST),
        .full_in_i       (full_in_i),
        .boxed_in_i      (boxed_in_i),
        .boxed_en_i      (boxed_en_i),
        .active_i        (active_i),
        .out_i           (out_i),
        .shift_i         (shift_i),
        .cfg_ack_i       (cfg_ack_i),
        .pos_1st_o       (pos_1st_o),
        .in_needed_o     (in_needed_o),
        .in_full_o       (in_full_o),
        .out_o           (out_o),
        .interp_factor_o (interp_factor_o),
        .cfg_valid_o     (cfg_valid_o),
        .cfg_err_o       (cfg_err_o),
        .busy_o          (busy_o)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Reference arithmetic written directly from the behavioural description
    function automatic exp_t model(input int full, input int boxed, input bit en,
                                   input int active, input int out, input int shift);
        exp_t e;
        longint base, off, f, p, raw, needed, lim, s;
        base = (en && boxed <= full) ? boxed : full;
        off  = (en && boxed <= full) ? (full - boxed) / 2 : 0;
        if (out == 0) begin
            f      = (64'sd1 << FRAC_W) - 1;
            needed = base;
            e.err  = 1'b1;
        end else begin
            f      = (64'sd1 << (FRAC_W - 1)) / out;
            p      = f * base * active;
            raw    = (p >> (FRAC_W - 1)) + ((p >> (FRAC_W - 2)) & 1);
            needed = (raw < base) ? raw : base;
            e.err  = 1'b0;
        end
        lim = base - needed;
        s   = lim / 2 + shift;
        if (s < 0)   s = 0;
        if (s > lim) s = lim;
        e.pos    = IN_W'(s + off);
        e.needed = IN_W'(needed);
        e.full   = IN_W'(full);
        e.out    = OUT_W'(out);
        e.f      = FRAC_W'(f);
        return e;
    endfunction

    task automatic drive(input int full, input int boxed, input bit en,
                         input int active, input int out, input int shift);
        @(negedge SYS_CLK);
        full_in_i  = full[IN_W-1:0];
        boxed_in_i = boxed[IN_W-1:0];
        boxed_en_i = en;
        active_i   = active[ACT_W-1:0];
        out_i      = out[OUT_W-1:0];
        shift_i    = shift[IN_W-1:0];
    endtask

    task automatic apply(input int full, input int boxed, input bit en,
                         input int active, input int out, input int shift);
        drive(full, boxed, en, active, out, shift);
        sb.push_back(model(full, boxed, en, active, out, shift));
    endtask

    // Wait (bounded) for a presented config and compare it to the queue head
    task automatic wait_and_compare(input string name);
        int n = 0;
        while (cfg_valid_o !== 1'b1 && n < 400) begin
            @(negedge SYS_CLK);
            n++;
        end
        checks++;
        if (cfg_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL %s valid_timeout: cfg_valid_o=%b after %0d cycles, required 1", name, cfg_valid_o, n);
            return;
        end
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected_present: pos=%0d needed=%0d, required no present", name, pos_1st_o, in_needed_o);
            return;
        end
        cur = sb.pop_front();
        checks++;
        if (pos_1st_o !== cur.pos) begin
            fails++;
            $display("FAIL %s pos_1st: got %0d, required %0d", name, pos_1st_o, cur.pos);
        end
        checks++;
        if (in_needed_o !== cur.needed) begin
            fails++;
            $display("FAIL %s in_needed: got %0d, required %0d", name, in_needed_o, cur.needed);
        end
        checks++;
        if (in_full_o !== cur.full) begin
            fails++;
            $display("FAIL %s in_full: got %0d, required %0d", name, in_full_o, cur.full);
        end
        checks++;
        if (out_o !== cur.out) begin
            fails++;
            $display("FAIL %s out: got %0d, required %0d", name, out_o, cur.out);
        end
        checks++;
        if (interp_factor_o !== cur.f) begin
            fails++;
            $display("FAIL %s interp_factor: got 0x%0h, required 0x%0h", name, interp_factor_o, cur.f);
        end
        checks++;
        if (cfg_err_o !== cur.err) begin
            fails++;
            $display("FAIL %s cfg_err: got %b, required %b", name, cfg_err_o, cur.err);
        end
    endtask

    // Outputs must hold without ack; valid drops the cycle after ack
    task automatic hold_and_ack(input string name, input int hold);
        bit bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge SYS_CLK);
            if (cfg_valid_o !== 1'b1 || pos_1st_o !== cur.pos || in_needed_o !== cur.needed ||
                interp_factor_o !== cur.f || cfg_err_o !== cur.err)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL %s hold: valid=%b pos=%0d needed=%0d, required held 1/%0d/%0d", name,
                     cfg_valid_o, pos_1st_o, in_needed_o, cur.pos, cur.needed);
        end
        cfg_ack_i = 1'b1;
        @(negedge SYS_CLK);
        cfg_ack_i = 1'b0;
        checks++;
        if (cfg_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL %s valid_after_ack: got %b, required 0", name, cfg_valid_o);
        end
    endtask

    task automatic present(input string name);
        wait_and_compare(name);
        hold_and_ack(name, 3);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge SYS_CLK);
            if (cfg_valid_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || sb.size() != 0) begin
            fails++;
            $display("FAIL %s quiet: extra present=%b pending=%0d, required 0/0", name, seen, sb.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (pos_1st_o !== '0 || in_needed_o !== '0 || in_full_o !== '0 || out_o !== '0 ||
            interp_factor_o !== '0 || cfg_valid_o !== 1'b0 || cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s reset_state: pos=%0d needed=%0d full=%0d out=%0d F=%0h valid=%b err=%b busy=%b, required all 0",
                     name, pos_1st_o, in_needed_o, in_full_o, out_o, interp_factor_o, cfg_valid_o, cfg_err_o, busy_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge SYS_CLK);
        check_all_zero("reset");
        SYS_RST = 1'b0;
        cfg_ack_i = 1'b1;
        @(negedge SYS_CLK);
        cfg_ack_i = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        check_all_zero("idle_ack_ignored");
    endtask

    task automatic test_unity();
        apply(240, 0, 1'b0, 480, 480, 0);
        wait_and_compare("unity");
        hold_and_ack("unity", 8);
    endtask

    task automatic test_downscale();
        apply(240, 0, 1'b0, 960, 1080, 0);
        present("downscale");
    endtask

    task automatic test_boxed();
        apply(288, 240, 1'b1, 480, 480, 0);
        present("boxed");
        apply(240, 288, 1'b1, 480, 480, 0);
        present("boxed_gt_full");
    endtask

    task automatic test_shift();
        apply(240, 0, 1'b0, 960, 1080, 20);
        present("shift_pos_clamp");
        apply(240, 0, 1'b0, 960, 1080, -20);
        present("shift_neg_clamp");
    endtask

    task automatic test_out_zero();
        apply(240, 0, 1'b0, 480, 0, 0);
        present("out_zero");
        apply(240, 0, 1'b0, 480, 480, 0);
        present("out_zero_recover");
    endtask

    task automatic test_back_to_back();
        apply(640, 0, 1'b0, 720, 720, 0);
        wait_and_compare("b2b_first");
        apply(320, 0, 1'b0, 1280, 1440, -5);
        hold_and_ack("b2b_first", 4);
        present("b2b_second");
    endtask

    task automatic test_restart();
        int n = 0;
        drive(240, 0, 1'b0, 480, 480, 0);
        while (busy_o !== 1'b1 && n < 20) begin
            @(negedge SYS_CLK);
            n++;
        end
        repeat (5) @(negedge SYS_CLK);
        apply(240, 0, 1'b0, 480, 1080, 0);
        present("restart_mid_div");
        expect_quiet("restart_single", 60);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        drive(288, 240, 1'b1, 480, 960, 0);
        while (busy_o !== 1'b1 && n < 20) begin
            @(negedge SYS_CLK);
            n++;
        end
        repeat (21) @(negedge SYS_CLK);
        checks++;
        if (cfg_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid pre_reset: valid=%b busy=%b, required 0/1", cfg_valid_o, busy_o);
        end
        SYS_RST = 1'b1;
        #1;
        check_all_zero("reset_mid_calc");
        repeat (2) @(negedge SYS_CLK);
        sb.delete();
        SYS_RST = 1'b0;
        sb.push_back(model(288, 240, 1'b1, 480, 960, 0));
        present("after_reset_mid");
    endtask

    initial begin
        test_reset();
        test_unity();
        test_downscale();
        test_boxed();
        test_shift();
        test_out_zero();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
